fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch sequencer: the reader side of the program counter. It reads the current PC, fetches the instruction word from instruction memory over a req/ack handshake, and hands it to the decode/control stage. It then drives the PC-source select and PC-write strobe back into the PC register block to advance or redirect the PC. It sits between the PC block, instruction memory and the main control unit.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles a fetch waits for `memAck`. Used only with `FETCH_TIMEOUT_EN`; valid range 1–255.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pcCur`  in  16  current PC from the PC block.
- `memReq`  out  1  instruction memory read request.
- `memAddr`  out  16  instruction memory read address.
- `memAck`  in  1  memory response strobe; `memData` is valid in the same cycle.
- `memData`  in  16  instruction word.
- `instr`  out  16  latched instruction to control.
- `instrValid`  out  1  `instr` is valid and awaiting acceptance.
- `instrAccept`  in  1  control consumes `instr`.
- `redirect`  in  1  control requests a non-sequential PC; sampled only together with `instrAccept`.
- `redirectSrc`  in  4  PC-source code used when `redirect`=1.
- `pcSrc`  out  4  PC mux select driven to the PC block.
- `pcWrite`  out  1  PC register write enable.
- `fetchFault`  out  1  sticky fetch-timeout flag. Tied 0 unless `FETCH_TIMEOUT_EN` is defined.

## Operation
- The FSM has six states: RESET, FETCH, DELIVER, SELECT, COMMIT and FAULT.
- **RESET:** all outputs are 0 (`instr`=0x0000, `pcSrc`=4'b0000). The FSM moves to FETCH on the first cycle with `reset` low.
- **FETCH:**
  - `memReq`=1 and `memAddr`=`pcCur`.
  - `memAck` is ignored whenever `memReq`=0.
  - On `memAck`=1, `instr` is loaded from `memData`, `memReq` drops, and the FSM moves to DELIVER.
- **DELIVER:**
  - `instrValid`=1 and `instr` is held stable.
  - On `instrAccept`=1, `pcSrc` is latched as `redirect ? redirectSrc : 4'b0000` (4'b0000 selects PC+2). `instrValid` drops and the FSM moves to SELECT.
- **SELECT:** `pcSrc` is driven stable and `pcWrite`=0. This cycle exists because the PC block registers its mux output one edge before the PC register loads it.
- **COMMIT:** `pcSrc` is held and `pcWrite`=1 for exactly one cycle. The FSM then moves to FETCH.
- **pcSrc hold rule:** `pcSrc` holds its last value outside SELECT/COMMIT. It returns to 4'b0000 only on reset.
- **Upper-bit codes:** redirect codes 4'b1xxx are passed through unchanged. The PC block ignores the upper bit.
- **Wrap-around:** the sequencer does no PC arithmetic. Wrap from 0xFFFE to 0x0000 is owned by the PC block; `memAddr` simply tracks `pcCur`.
- **Alignment:** an odd `pcCur` is issued to memory unmodified.
- **Reset mid-operation:** a reset in any state aborts the operation. `memReq`, `instrValid` and `pcWrite` are 0 from the cycle after the reset edge. A pending fetch is abandoned, and a late `memAck` is ignored.

## Timing
- **Fetch latency:** `memReq` rises the cycle after entering FETCH. With `memAck` in the same cycle as `memReq`, `instrValid` rises on the next edge.
- **Minimum loop:** FETCH(1) + DELIVER(1) + SELECT(1) + COMMIT(1) = 4 cycles per instruction, with zero-wait memory and immediate accept.
- **Wait states:** memory wait extends FETCH by one cycle per wait state. Withheld `instrAccept` extends DELIVER by one cycle per cycle withheld.
- **PC update:** the new `pcCur` is visible in the cycle after COMMIT, which is the first FETCH cycle. `memAddr` follows it combinationally.
- **`pcWrite`:** never asserted outside COMMIT, and never held for two consecutive cycles.

## Configuration
- **`FETCH_TIMEOUT_EN` defined:**
  - An 8-bit wait counter clears on entry to FETCH and increments each FETCH cycle without `memAck`.
  - When the counter reaches `TIMEOUT_CYCLES`, `memReq` drops, `fetchFault` is set and the FSM enters FAULT.
  - FAULT is left only by reset. In FAULT, `pcWrite`=0 and `instrValid`=0.
  - A `memAck` arriving in the same cycle the count reaches its limit wins: it is a normal fetch and no fault is raised.
- **`FETCH_TIMEOUT_EN` undefined:** there is no counter and no FAULT state, FETCH waits indefinitely, and `fetchFault` is constant 0.

## Test plan
- **Reset:** hold reset 3 cycles → `memReq`, `instrValid`, `pcWrite` and `fetchFault` are 0, and `pcSrc`=0. First fetch has `memAddr`=0x0000 when `pcCur`=0x0000.
- **Sequential fetch:** `pcCur`=0x0010, `memAck` same cycle with `memData`=0xA5C3, `instrAccept` immediate, `redirect`=0 → `instr`=0xA5C3. `pcSrc`=0 for SELECT and COMMIT, with `pcWrite` high only in COMMIT. Loop is 4 cycles.
- **Redirect:** accept with `redirect`=1 and `redirectSrc`=4'b0011 → `pcSrc`=3 in SELECT and COMMIT, and 3 persists into the next FETCH. The next `memAddr` equals the new `pcCur`.
- **Backpressure:** memory with 3 wait states and accept withheld 2 cycles → `memReq` high for 4 cycles. `instr` is stable and `instrValid` high for 3 cycles. Total loop is 9 cycles.
- **Reset mid-fetch:** assert reset during FETCH, then assert `memAck` one cycle later → the ack is ignored, `instrValid` stays 0, and a fresh FETCH is issued after reset.
- **Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** no `memAck` → `fetchFault`=1 after 4 FETCH cycles and `memReq`=0. The fault holds until reset. A variant with ack on cycle 4 → no fault.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch sequencer sitting between the PC block,
//                instruction memory and the main control unit. It reads the
//                current PC, fetches the instruction word over a req/ack
//                handshake and hands it to control. It then drives the
//                PC-source select and a one-cycle PC-write strobe back to the
//                PC block.
//
//  Optional feature macro:
//      FETCH_TIMEOUT_EN - enables an 8-bit fetch wait counter. A fetch that
//                         sees no memAck within TIMEOUT_CYCLES FETCH cycles
//                         raises the sticky fetchFault flag and parks the FSM
//                         in FAULT until reset.
//
//  Parameters:
//      TIMEOUT_CYCLES  maximum FETCH cycles without memAck (1..255); only
//                      meaningful with FETCH_TIMEOUT_EN
//
//  Ports:
//      clock        in   1   system clock, rising edge
//      reset        in   1   synchronous active-high reset
//      pcCur        in  16   current PC from the PC block
//      memReq       out  1   instruction memory read request
//      memAddr      out 16   instruction memory read address (= pcCur)
//      memAck       in   1   memory response strobe, memData valid with it
//      memData      in  16   instruction word from memory
//      instr        out 16   latched instruction to control
//      instrValid   out  1   instr valid, awaiting acceptance
//      instrAccept  in   1   control consumes instr
//      redirect     in   1   non-sequential PC request (with instrAccept)
//      redirectSrc  in   4   PC-source code used when redirect=1
//      pcSrc        out  4   PC mux select to the PC block
//      pcWrite      out  1   PC register write enable
//      fetchFault   out  1   sticky fetch-timeout flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pcCur,
    output logic        memReq,
    output logic [15:0] memAddr,
    input  logic        memAck,
    input  logic [15:0] memData,
    output logic [15:0] instr,
    output logic        instrValid,
    input  logic        instrAccept,
    input  logic        redirect,
    input  logic [3:0]  redirectSrc,
    output logic [3:0]  pcSrc,
    output logic        pcWrite,
    output logic        fetchFault
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_RESET   = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_DELIVER = 3'd2;
    localparam logic [2:0] c_ST_SELECT  = 3'd3;
    localparam logic [2:0] c_ST_COMMIT  = 3'd4;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [2:0] c_ST_FAULT   = 3'd5;
`endif

    // Sequential PC advance (PC+2) is PC-source code zero.
    localparam logic [3:0] c_SRC_SEQ = 4'b0000;

    logic [2:0]  r_state;
    logic [2:0]  w_stateNext;
    logic [15:0] r_instr;
    logic [3:0]  r_pcSrc;
    logic        w_inFetch;
    logic        w_fetchDone;
    logic        w_accept;
    logic        w_timeout;

    assign w_inFetch   = (r_state == c_ST_FETCH);
    // memAck only counts while a request is actually outstanding.
    assign w_fetchDone = w_inFetch && memAck;
    assign w_accept    = (r_state == c_ST_DELIVER) && instrAccept;

    // ------------------------------------------------------------------------
    // Optional fetch timeout
    // ------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_waitCount;
    logic       r_fault;

    // The counter holds the number of ack-less FETCH cycles already spent.
    // The fault fires in the cycle whose miss would bring it to the limit,
    // so an ack in that same cycle still completes the fetch normally.
    assign w_timeout = w_inFetch && !memAck && (r_waitCount == c_TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_waitCount <= 8'd0;
        end else if (w_inFetch && !memAck) begin
            r_waitCount <= r_waitCount + 8'd1;
        end else begin
            // Outside FETCH the counter sits at zero, so every FETCH entry
            // starts from a clean count.
            r_waitCount <= 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_timeout) begin
            r_fault <= 1'b1;
        end
    end

    assign fetchFault = r_fault;
`else
    logic [31:0] w_unusedTimeout;

    assign w_unusedTimeout = TIMEOUT_CYCLES;
    assign w_timeout       = 1'b0;
    assign fetchFault      = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_RESET: begin
                // Reset itself is handled in the state register, so reaching
                // this point means reset is low this cycle.
                w_stateNext = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (w_fetchDone) begin
                    w_stateNext = c_ST_DELIVER;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_timeout) begin
                    w_stateNext = c_ST_FAULT;
                end
`endif
            end
            c_ST_DELIVER: begin
                if (instrAccept) begin
                    w_stateNext = c_ST_SELECT;
                end
            end
            c_ST_SELECT: begin
                // Gives the PC block one edge to register its mux output
                // before the PC register is written.
                w_stateNext = c_ST_COMMIT;
            end
            c_ST_COMMIT: begin
                w_stateNext = c_ST_FETCH;
            end
`ifdef FETCH_TIMEOUT_EN
            c_ST_FAULT: begin
                w_stateNext = c_ST_FAULT;
            end
`endif
            default: begin
                w_stateNext = c_ST_RESET;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr <= 16'h0000;
        end else if (w_fetchDone) begin
            r_instr <= memData;
        end
    end

    // pcSrc is loaded only on acceptance and otherwise holds, so the last
    // select stays on the PC mux through the following FETCH. Upper-bit
    // codes pass through untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pcSrc <= c_SRC_SEQ;
        end else if (w_accept) begin
            r_pcSrc <= redirect ? redirectSrc : c_SRC_SEQ;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign memReq     = w_inFetch;
    // The address tracks pcCur combinationally, with no alignment or wrap
    // handling; both belong to the PC block.
    assign memAddr    = w_inFetch ? pcCur : 16'h0000;
    assign instr      = r_instr;
    assign instrValid = (r_state == c_ST_DELIVER);
    assign pcSrc      = r_pcSrc;
    assign pcWrite    = (r_state == c_ST_COMMIT);

endmodule
`default_nettype wire
